usb_tx_seq: RTL

//  Host-side USB transmit sequencer; sits upstream of the dpdm line driver and

---
 rtl/usb_tx_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_seq.sv
// Purpose : host-side USB transmit sequencer; SYNC + LSB-first payload with bit stuffing, NRZI coded, then EOP and inter-packet gap.
// Latency : start_dpdm/tx_ready in the accepting IDLE cycle, first SYNC bit on s_in the next cycle, eop the cycle after the last bit (or stuffed bit).
// Backpr. : bytes are taken only on the start cycle and on each byte's bit-7 cycle; tx_valid low at a byte boundary aborts the packet (eop + tx_err).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_valid/tx_data/
//   tx_last/tx_ready    packet byte stream (PID first); transfer = tx_valid & tx_ready
//   dpdm_enable         line driver busy; a packet starts only while it is low
//   start_dpdm          1-cycle pulse, driver leaves WAIT next cycle
//   s_in                NRZI line level to the driver (1=J, 0=K)
//   eop                 1-cycle pulse, driver begins SE0,SE0,J
//   busy                high from the start_dpdm cycle through the last gap cycle
//   tx_done             1-cycle pulse in the first gap cycle
//   tx_err              1-cycle pulse together with eop on an underrun abort
module usb_tx_seq #(
  parameter logic [7:0] SYNC_BYTE  = 8'h80,
  parameter int         MAX_ONES   = 6,
  parameter int         IPG_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       dpdm_enable,
  output logic       start_dpdm,
  output logic       s_in,
  output logic       eop,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, EOPW, GAP} state_t;

  state_t     state;
  logic [7:0] cnt;              // SYNC bit index, EOPW and GAP cycle counter
  logic [7:0] shifter;
  logic [2:0] bit_cnt;          // bit cycle: index on the line; stuff cycle: index of the next bit
  logic [3:0] ones_cnt;
  logic       last_flag;
  logic       stuff_cyc;        // current cycle carries a stuffed 0
  logic       end_after_stuff;  // stuffed 0 follows the final payload bit

  logic       byte_end;
  logic       stuff_due;
  logic       emit_raw;
  logic       raw_bit;
  logic       emit_stuff;

  assign start_dpdm = (state == IDLE) && tx_valid && !dpdm_enable;
  assign byte_end   = (state == DATA) && !stuff_cyc && (bit_cnt == 3'd7);
  assign tx_ready   = start_dpdm || (byte_end && !last_flag);
  assign busy       = (state != IDLE) || start_dpdm;
  assign stuff_due  = (ones_cnt == 4'(MAX_ONES));

  // Decide what the line carries in the next cycle; the register update below
  // applies it so that s_in always shows the level after the current bit.
  always_comb begin
    emit_raw   = 1'b0;
    raw_bit    = 1'b0;
    emit_stuff = 1'b0;
    case (state)
      IDLE: begin
        if (start_dpdm) begin
          emit_raw = 1'b1;
          raw_bit  = SYNC_BYTE[0];
        end
      end
      SYNC: begin
        emit_raw = 1'b1;
        raw_bit  = (cnt[2:0] == 3'd7) ? shifter[0] : SYNC_BYTE[cnt[2:0] + 3'd1];
      end
      DATA: begin
        if (stuff_cyc) begin
          if (!end_after_stuff) begin
            emit_raw = 1'b1;
            raw_bit  = shifter[bit_cnt];
          end
        end else if (byte_end && !last_flag && !tx_valid) begin
          // underrun: abort straight to EOP, a pending stuff is dropped
        end else if (stuff_due) begin
          emit_stuff = 1'b1;
        end else if (byte_end) begin
          if (!last_flag) begin
            emit_raw = 1'b1;
            raw_bit  = tx_data[0];
          end
        end else begin
          emit_raw = 1'b1;
          raw_bit  = shifter[bit_cnt + 3'd1];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      shifter         <= '0;
      bit_cnt         <= '0;
      ones_cnt        <= '0;
      last_flag       <= 1'b0;
      stuff_cyc       <= 1'b0;
      end_after_stuff <= 1'b0;
      s_in            <= 1'b1;
      eop             <= 1'b0;
      tx_done         <= 1'b0;
      tx_err          <= 1'b0;
    end else begin
      eop     <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;

      // NRZI: a 0 (raw or stuffed) toggles the line, a 1 holds it
      if (emit_stuff) begin
        s_in     <= ~s_in;
        ones_cnt <= '0;
      end else if (emit_raw) begin
        if (raw_bit) begin
          ones_cnt <= ones_cnt + 4'd1;
        end else begin
          ones_cnt <= '0;
          s_in     <= ~s_in;
        end
      end

      case (state)
        IDLE: begin
          if (start_dpdm) begin
            state           <= SYNC;
            cnt             <= '0;
            shifter         <= tx_data;
            last_flag       <= tx_last;
            bit_cnt         <= '0;
            stuff_cyc       <= 1'b0;
            end_after_stuff <= 1'b0;
          end
        end
        SYNC: begin
          if (cnt[2:0] == 3'd7) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (stuff_cyc) begin
            stuff_cyc <= 1'b0;
            if (end_after_stuff) begin
              state <= EOP;
              eop   <= 1'b1;
            end
          end else if (byte_end) begin
            if (last_flag) begin
              if (stuff_due) begin
                stuff_cyc       <= 1'b1;
                end_after_stuff <= 1'b1;
              end else begin
                state <= EOP;
                eop   <= 1'b1;
              end
            end else if (tx_valid) begin
              shifter   <= tx_data;
              last_flag <= tx_last;
              bit_cnt   <= '0;
              stuff_cyc <= stuff_due;
            end else begin
              state  <= EOP;
              eop    <= 1'b1;
              tx_err <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 3'd1;
            stuff_cyc <= stuff_due;
          end
        end
        EOP: begin
          state    <= EOPW;
          cnt      <= '0;
          s_in     <= 1'b1;
          ones_cnt <= '0;
        end
        EOPW: begin
          if (cnt == 8'd1) begin
            state   <= GAP;
            cnt     <= '0;
            tx_done <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'(IPG_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
